// File: rtl/spi_ram_pkg.sv
// -----------------------------------------------------------------------------
// spi_ram_pkg
// Shared definitions for the SPI RAM command master: command opcodes, the
// controller state encoding, default data width and a command-word builder.
// Optional feature macro used by the design: SPI_RAM_ADDR_CACHE_EN.
// -----------------------------------------------------------------------------
package spi_ram_pkg;

  localparam int DEFAULT_ADDR_SIZE = 8;
  localparam int PAYLOAD_W         = 8;
  localparam int DIN_W             = 2 + PAYLOAD_W;

  // Command opcodes carried in the top two bits of every RAM word.
  localparam logic [1:0] OP_WR_ADDR  = 2'b00;
  localparam logic [1:0] OP_WR_DATA  = 2'b01;
  localparam logic [1:0] OP_RD_ADDR  = 2'b10;
  localparam logic [1:0] OP_RD_FETCH = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_CMD,
    RD_WAIT,
    RSP
  } state_e;

  function automatic logic [DIN_W-1:0] ram_word(input logic [1:0]           op,
                                                input logic [PAYLOAD_W-1:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/spi_ram_master_if.sv
// -----------------------------------------------------------------------------
// spi_ram_master_if
// Request/response handshake plus the RAM-slave command/data link.
//   req_valid/req_ready/req_wr/req_addr/req_wdata : request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err         : response channel
//   ram_din/ram_rx_valid                          : command words to RAM slave
//   ram_dout/ram_tx_valid                         : read data from RAM slave
// Modports: master (the spi_ram_master side), slave (the environment side).
// -----------------------------------------------------------------------------
interface spi_ram_master_if #(
  parameter int ADDR_SIZE = spi_ram_pkg::DEFAULT_ADDR_SIZE
);
  logic                          req_valid;
  logic                          req_ready;
  logic                          req_wr;
  logic [ADDR_SIZE-1:0]          req_addr;
  logic [ADDR_SIZE-1:0]          req_wdata;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [ADDR_SIZE-1:0]          rsp_rdata;
  logic                          rsp_err;
  logic [spi_ram_pkg::DIN_W-1:0] ram_din;
  logic                          ram_rx_valid;
  logic [ADDR_SIZE-1:0]          ram_dout;
  logic                          ram_tx_valid;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, ram_dout, ram_tx_valid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready, ram_dout, ram_tx_valid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid
  );
endinterface

// File: rtl/spi_ram_master_tmo.sv
// -----------------------------------------------------------------------------
// spi_ram_master_tmo
// Read-wait timeout down-counter.
//   clk, rst_n  : clock, async active-low reset
//   load_i      : reload so that expired_o rises after TIMEOUT enabled cycles
//   en_i        : count down one step (saturates at zero)
//   expired_o   : high when the count has reached zero
// -----------------------------------------------------------------------------
module spi_ram_master_tmo #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Loading TIMEOUT-1 makes the last of TIMEOUT wait cycles see expired_o=1.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                 cnt_d = CW'(TIMEOUT - 1);
    else if (en_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/spi_ram_master.sv
// -----------------------------------------------------------------------------
// spi_ram_master
// Turns single read/write requests into RAM-slave command words
// {opcode, payload} and returns one response per request.
//   clk, rst_n : clock, async active-low reset
//   bus        : spi_ram_master_if.master (request, response, RAM link)
// Parameters: ADDR_SIZE (address/data width), TIMEOUT (max read-wait cycles).
// Optional feature: define SPI_RAM_ADDR_CACHE_EN to remember the last issued
// write and read addresses and skip re-sending a matching address word.
// -----------------------------------------------------------------------------
module spi_ram_master import spi_ram_pkg::*; #(
  parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_ram_master_if.master  bus
);
  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
  logic [ADDR_SIZE-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [DIN_W-1:0]     din_q, din_d;
  logic                 rx_q, rx_d;
  logic                 tmo_load, tmo_en, tmo_expired;
  logic                 wr_hit, rd_hit;

  spi_ram_master_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmo_load),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );

`ifdef SPI_RAM_ADDR_CACHE_EN
  logic [ADDR_SIZE-1:0] wr_cache_q, rd_cache_q;
  logic                 wr_cache_vld_q, rd_cache_vld_q;

  // NOTE: the cached addresses are reset along with their valid bits; the
  // contents are meaningless while invalid, but resetting keeps them
  // deterministic and costs nothing at this size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cache_q     <= '0;
      wr_cache_vld_q <= 1'b0;
      rd_cache_q     <= '0;
      rd_cache_vld_q <= 1'b0;
    end else begin
      if (state_q == WR_ADDR) begin
        wr_cache_q     <= addr_q;
        wr_cache_vld_q <= 1'b1;
      end
      if (state_q == RD_ADDR) begin
        rd_cache_q     <= addr_q;
        rd_cache_vld_q <= 1'b1;
      end
    end
  end

  assign wr_hit = wr_cache_vld_q && (wr_cache_q == bus.req_addr);
  assign rd_hit = rd_cache_vld_q && (rd_cache_q == bus.req_addr);
`else
  assign wr_hit = 1'b0;
  assign rd_hit = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    din_d    = din_q;   // ram_din holds its last word between pulses
    rx_d     = 1'b0;
    tmo_load = 1'b0;
    tmo_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (bus.req_wr) state_d = wr_hit ? WR_DATA : WR_ADDR;
          else            state_d = rd_hit ? RD_CMD  : RD_ADDR;
        end
      end
      WR_ADDR: begin
        din_d   = ram_word(OP_WR_ADDR, PAYLOAD_W'(addr_q));
        rx_d    = 1'b1;
        state_d = WR_DATA;
      end
      WR_DATA: begin
        din_d   = ram_word(OP_WR_DATA, PAYLOAD_W'(wdata_q));
        rx_d    = 1'b1;
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = RSP;
      end
      RD_ADDR: begin
        din_d   = ram_word(OP_RD_ADDR, PAYLOAD_W'(addr_q));
        rx_d    = 1'b1;
        state_d = RD_CMD;
      end
      RD_CMD: begin
        din_d    = ram_word(OP_RD_FETCH, '0);
        rx_d     = 1'b1;
        tmo_load = 1'b1;
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        tmo_en = 1'b1;
        // Data arriving on the final allowed cycle still wins over the timeout.
        if (bus.ram_tx_valid) begin
          rdata_d = bus.ram_dout;
          err_d   = 1'b0;
          state_d = RSP;
        end else if (tmo_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RSP;
        end
      end
      RSP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      din_q   <= '0;
      rx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      din_q   <= din_d;
      rx_q    <= rx_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.rsp_valid    = (state_q == RSP);
  assign bus.rsp_rdata    = rdata_q;
  assign bus.rsp_err      = err_q;
  assign bus.ram_din      = din_q;
  assign bus.ram_rx_valid = rx_q;
endmodule

// File: tb/tb_spi_ram_master.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_master
// Self-checking bench for spi_ram_master. A transaction-level reference model
// predicts, per request, the ordered RAM command words, the response cycle
// and the response contents from the protocol rules (opcodes, per-step
// latency, timeout length, address cache behaviour when
// SPI_RAM_ADDR_CACHE_EN is defined).
// -----------------------------------------------------------------------------
module tb_spi_ram_master;
  import spi_ram_pkg::*;

  localparam int AW  = 8;
  localparam int TMO = 16;
`ifdef SPI_RAM_ADDR_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  spi_ram_master_if #(.ADDR_SIZE(AW)) bus ();

  spi_ram_master #(.ADDR_SIZE(AW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of the address caches (only consulted when CACHE_EN).
  bit         m_wr_vld, m_rd_vld;
  logic [7:0] m_wr_addr, m_rd_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wr_vld  = 1'b0;
    m_rd_vld  = 1'b0;
    m_wr_addr = '0;
    m_rd_addr = '0;
  endtask

  // One complete request/response. tx_delay: RD_WAIT cycles with
  // ram_tx_valid low before it rises (>= TMO means never). hold: cycles
  // rsp_ready stays low after the response appears.
  task automatic run_txn(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] sdata, input int tx_delay, input int hold);
    logic [9:0] exp_w[$];
    logic [7:0] exp_rdata;
    bit         hit, exp_err;
    int         lat, tx_cyc, wait_start, widx, rsp_cyc;

    hit = CACHE_EN && (wr ? (m_wr_vld && m_wr_addr == addr) : (m_rd_vld && m_rd_addr == addr));
    tx_cyc = -1;
    if (wr) begin
      if (!hit) exp_w.push_back({OP_WR_ADDR, addr});
      exp_w.push_back({OP_WR_DATA, wdata});
      lat       = 3 - int'(hit);
      exp_err   = 1'b0;
      exp_rdata = '0;
      if (CACHE_EN) begin m_wr_vld = 1'b1; m_wr_addr = addr; end
    end else begin
      if (!hit) exp_w.push_back({OP_RD_ADDR, addr});
      exp_w.push_back({OP_RD_FETCH, 8'h00});
      wait_start = 3 - int'(hit);   // cycle index of the first RD_WAIT cycle
      if (tx_delay >= TMO) begin
        lat       = wait_start + TMO;
        exp_err   = 1'b1;
        exp_rdata = '0;
      end else begin
        tx_cyc    = wait_start + tx_delay;
        lat       = tx_cyc + 1;
        exp_err   = 1'b0;
        exp_rdata = sdata;
      end
      if (CACHE_EN) begin m_rd_vld = 1'b1; m_rd_addr = addr; end
    end

    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_wr       = wr;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.ram_dout     = sdata;
    bus.ram_tx_valid = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;

    widx    = 0;
    rsp_cyc = 0;
    for (int n = 1; n <= 40 && rsp_cyc == 0; n++) begin
      @(negedge clk);
      if (n == tx_cyc) bus.ram_tx_valid = 1'b1;
      if (bus.ram_rx_valid) begin
        check("word_cycle", 32'(n), 32'(2 + widx));
        if (widx < exp_w.size()) check("word_value", 32'(bus.ram_din), 32'(exp_w[widx]));
        else                     check("extra_word", 32'(widx), 32'(exp_w.size()));
        widx++;
      end
      if (bus.rsp_valid) rsp_cyc = n;
    end
    check("word_count", 32'(widx), 32'(exp_w.size()));
    check("rsp_latency", 32'(rsp_cyc), 32'(lat));
    check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
      check("hold_err", 32'(bus.rsp_err), 32'(exp_err));
      check("hold_ready", 32'(bus.req_ready), 32'd0);
      check("hold_no_word", 32'(bus.ram_rx_valid), 32'd0);
    end

    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready    = 1'b0;
    bus.ram_tx_valid = 1'b0;
    @(negedge clk);
    check("rsp_released", 32'(bus.rsp_valid), 32'd0);
    check("ready_after_rsp", 32'(bus.req_ready), 32'd1);
  endtask

  // Write accepted, reset asserted while the address word is on ram_din.
  task automatic reset_mid_write(input logic [7:0] addr, input logic [7:0] wdata);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_word", 32'(bus.ram_din), 32'({OP_WR_ADDR, addr}));
    rst_n = 1'b0;
    #1;
    check("rst_rx_valid", 32'(bus.ram_rx_valid), 32'd0);
    check("rst_din", 32'(bus.ram_din), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("post_rst_no_word", 32'(bus.ram_rx_valid), 32'd0);
      check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_wr       = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b0;
    bus.ram_dout     = '0;
    bus.ram_tx_valid = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_din", 32'(bus.ram_din), 32'd0);
    check("reset_rx_valid", 32'(bus.ram_rx_valid), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("reset_err", 32'(bus.rsp_err), 32'd0);
    rst_n = 1'b1;

    // Directed: write, read, timeout, boundary data, held response
    run_txn(1'b1, 8'h3C, 8'hA5, 8'h00, 0, 0);
    run_txn(1'b0, 8'h3C, 8'h00, 8'hA5, 0, 0);
    run_txn(1'b0, 8'h55, 8'h00, 8'h77, 99, 0);
    run_txn(1'b0, 8'h56, 8'h00, 8'h9E, TMO - 1, 0);
    run_txn(1'b0, 8'h66, 8'h00, 8'hC3, 2, 5);

    // Reset mid-transaction, then back-to-back reads/writes of one address
    reset_mid_write(8'h3C, 8'hA5);
    run_txn(1'b0, 8'h10, 8'h00, 8'h42, 0, 0);
    run_txn(1'b0, 8'h10, 8'h00, 8'h43, 0, 0);
    run_txn(1'b1, 8'h20, 8'h11, 8'h00, 0, 1);
    run_txn(1'b1, 8'h20, 8'h22, 8'h00, 0, 0);

    // Randomized traffic over a small address pool so cache hits occur
    for (int i = 0; i < 60; i++) begin
      bit         wr;
      logic [7:0] addr;
      int         dly;
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'h10 + $urandom_range(0, 1));
      dly  = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 5);
      run_txn(wr, addr, 8'($urandom), 8'($urandom), dly, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
